// File: rtl/lane_pipe_chain.sv
// lane_pipe_chain
//   Multi-lane in-order pipeline register chain: DEPTH stages x LANES slots,
//   each slot carrying valid, PC and payload. Sits between decode and
//   writeback and replaces the individual issue/exec/lsu/wb buffers.
//
//   Lane 0 is the oldest slot of a stage, higher lane indices are younger.
//   Stage 0 is the entry stage, stage DEPTH-1 drives the outputs.
//
// Ports
//   clock_i          core clock, all state updates on rising edge
//   reset_i          synchronous active-high reset, overrides everything
//   we_i             global advance
//   in_valid_i       entry slot valid, bit l = lane l
//   in_pc_i          entry PCs, lane l at [l*PC_W +: PC_W]
//   in_data_i        entry payloads, lane l at [l*DATA_W +: DATA_W]
//   hold_i           per-lane entry hold (stage 0 keeps, stage 1 gets a bubble)
//   redirect_i       mispredict resolved in REDIRECT_STG
//   redirect_lane_i  lane holding the mispredicted branch
//   stage_valid_o    valid of every slot, stage s lane l at bit s*LANES+l
//   out_valid_o      valid of stage DEPTH-1
//   out_pc_o         PCs of stage DEPTH-1
//   out_data_o       payloads of stage DEPTH-1
//   retired_cnt_o    count of valid slots leaving stage DEPTH-1 (wraps)
//
// Handshake: there is no per-slot ready. we_i is the single advance strobe;
// a slot is considered consumed by the backend on any edge where we_i=1 and
// its out_valid_o bit is set. Consumers must qualify PC/data with valid,
// since flushed and bubble slots keep stale PC/data.
module lane_pipe_chain #(
  parameter int LANES        = 2,
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 64,
  parameter int PC_W         = 32,
  parameter int REDIRECT_STG = 1,
  parameter int LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     we_i,
  input  logic [LANES-1:0]         in_valid_i,
  input  logic [LANES*PC_W-1:0]    in_pc_i,
  input  logic [LANES*DATA_W-1:0]  in_data_i,
  input  logic [LANES-1:0]         hold_i,
  input  logic                     redirect_i,
  input  logic [LANE_W-1:0]        redirect_lane_i,
  output logic [DEPTH*LANES-1:0]   stage_valid_o,
  output logic [LANES-1:0]         out_valid_o,
  output logic [LANES*PC_W-1:0]    out_pc_o,
  output logic [LANES*DATA_W-1:0]  out_data_o,
  output logic [31:0]              retired_cnt_o
);

  logic              valid_q [DEPTH][LANES];
  logic              valid_d [DEPTH][LANES];
  logic [PC_W-1:0]   pc_q    [DEPTH][LANES];
  logic [PC_W-1:0]   pc_d    [DEPTH][LANES];
  logic [DATA_W-1:0] data_q  [DEPTH][LANES];
  logic [DATA_W-1:0] data_d  [DEPTH][LANES];
  logic [31:0]       retired_cnt_q;
  logic [31:0]       retired_cnt_d;
  logic [31:0]       out_pop;

  // Next-state for every slot. Default is "hold"; advance, hold bubbles and
  // redirect kills are layered on top.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        int   src;
        logic kill_lane;
        src       = (s > 0) ? s - 1 : 0;
        // Lanes younger than the branch lane. An out-of-range lane index
        // naturally kills nothing.
        kill_lane = redirect_i && (LANE_W'(l) > redirect_lane_i);
        if (we_i) begin
          if (s == 0) begin
            if (redirect_i) begin
              // Entry never loads on a redirect. With a single stage the
              // slot stays put, so only the younger-lane kill applies;
              // otherwise its contents moved on and the entry empties.
              if (DEPTH == 1) begin
                if (kill_lane) valid_d[0][l] = 1'b0;
              end else begin
                valid_d[0][l] = 1'b0;
              end
            end else if (!hold_i[l]) begin
              valid_d[0][l] = in_valid_i[l];
              pc_d[0][l]    = in_pc_i[l*PC_W +: PC_W];
              data_d[0][l]  = in_data_i[l*DATA_W +: DATA_W];
            end
          end else begin
            valid_d[s][l] = valid_q[src][l];
            pc_d[s][l]    = pc_q[src][l];
            data_d[s][l]  = data_q[src][l];
            if (redirect_i && (s <= REDIRECT_STG)) begin
              // Fed by a stage that is being flushed.
              valid_d[s][l] = 1'b0;
            end else if (redirect_i && (s == REDIRECT_STG + 1) && kill_lane) begin
              valid_d[s][l] = 1'b0;
            end else if (!redirect_i && (s == 1) && hold_i[l]) begin
              // Held entry lane leaves a bubble behind it.
              valid_d[s][l] = 1'b0;
            end
          end
        end else if (redirect_i) begin
          if (s < REDIRECT_STG) begin
            valid_d[s][l] = 1'b0;
          end else if ((s == REDIRECT_STG) && kill_lane) begin
            valid_d[s][l] = 1'b0;
          end
        end
      end
    end
  end

  // Retirement: every valid output slot on an advancing edge.
  always_comb begin
    out_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      out_pop = out_pop + 32'(valid_q[DEPTH-1][l]);
    end
    retired_cnt_d = we_i ? (retired_cnt_q + out_pop) : retired_cnt_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int l = 0; l < LANES; l++) begin
          valid_q[s][l] <= 1'b0;
          pc_q[s][l]    <= '0;
          data_q[s][l]  <= '0;
        end
      end
      retired_cnt_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int l = 0; l < LANES; l++) begin
          valid_q[s][l] <= valid_d[s][l];
          pc_q[s][l]    <= pc_d[s][l];
          data_q[s][l]  <= data_d[s][l];
        end
      end
      retired_cnt_q <= retired_cnt_d;
    end
  end

  always_comb begin
    stage_valid_o = '0;
    out_valid_o   = '0;
    out_pc_o      = '0;
    out_data_o    = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        stage_valid_o[s*LANES + l] = valid_q[s][l];
      end
    end
    for (int l = 0; l < LANES; l++) begin
      out_valid_o[l]                = valid_q[DEPTH-1][l];
      out_pc_o[l*PC_W +: PC_W]      = pc_q[DEPTH-1][l];
      out_data_o[l*DATA_W +: DATA_W] = data_q[DEPTH-1][l];
    end
  end

  assign retired_cnt_o = retired_cnt_q;

endmodule
